// File: rtl/multi_user_free_queue.sv
// Free-pointer queue for the shared cell buffer: self-loads every cell pointer
// after reset, then serves show-ahead pops to ingress and takes pushes from egress.
module multi_user_free_queue #(
  parameter int unsigned PTR_W = 10,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [15:0]      ptr_din,
  input  logic             FQ_wr,
  input  logic             FQ_rd,
  output logic [PTR_W-1:0] ptr_dout_s,
  output logic             ptr_fifo_empty,
  output logic             FQ_act,
  output logic [AW:0]      FQ_count
);

  localparam int unsigned DIN_W = 16;
  localparam int unsigned CNT_W = AW + 1;

  typedef enum logic {ST_INIT, ST_ACTIVE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [AW-1:0]    init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             mem_we;
  logic [PTR_W-1:0] mem_wdata;
  logic [PTR_W-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Upper return-pointer bits carry no information for this buffer size.
  logic unused_din_hi;
  assign unused_din_hi = ^ptr_din[DIN_W-1:PTR_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_INIT;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      init_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      init_cnt_q <= init_cnt_d;
      count_q    <= count_d;
    end
  end

  // Init loads one pointer per cycle; active mode arbitrates push/pop with under/overflow guards.
  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    init_cnt_d = init_cnt_q;
    count_d    = count_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_wdata  = PTR_W'(init_cnt_q);
        wr_idx_d   = wr_idx_q + AW'(1);
        count_d    = count_q + CNT_W'(1);
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        do_pop  = FQ_rd && (count_q != '0);
        do_push = FQ_wr && (count_q != CNT_W'(DEPTH));
        if (do_pop) begin
          rd_idx_d = rd_idx_q + AW'(1);
        end
        if (do_push) begin
          mem_we    = 1'b1;
          mem_wdata = ptr_din[PTR_W-1:0];
          wr_idx_d  = wr_idx_q + AW'(1);
        end
        case ({do_push, do_pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Pointer storage has no reset; init overwrites every entry before use.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx_q] <= mem_wdata;
    end
  end

  assign ptr_dout_s     = mem_q[rd_idx_q];
  assign ptr_fifo_empty = (count_q == '0);
  assign FQ_act         = (state_q == ST_ACTIVE);
  assign FQ_count       = count_q;

endmodule

// File: tb/tb_multi_user_free_queue.sv
// Scoreboard bench for multi_user_free_queue: a queue model of expected pointers
// is checked against every pop, and count/empty/head are checked each cycle.
module tb_multi_user_free_queue;

  localparam int unsigned DEPTH = 512;

  logic        clk;
  logic        rstn;
  logic [15:0] ptr_din;
  logic        FQ_wr;
  logic        FQ_rd;
  logic [9:0]  ptr_dout_s;
  logic        ptr_fifo_empty;
  logic        FQ_act;
  logic [9:0]  FQ_count;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned sb[$];

  multi_user_free_queue dut (
    .clk            (clk),
    .rstn           (rstn),
    .ptr_din        (ptr_din),
    .FQ_wr          (FQ_wr),
    .FQ_rd          (FQ_rd),
    .ptr_dout_s     (ptr_dout_s),
    .ptr_fifo_empty (ptr_fifo_empty),
    .FQ_act         (FQ_act),
    .FQ_count       (FQ_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered on a negedge; drives one cycle of stimulus and updates the model.
  task automatic step(input logic wr, input logic rd, input logic [15:0] din);
    bit          do_pop, do_push;
    int unsigned exp_v;
    logic [9:0]  din_lo;
    FQ_wr   = wr;
    FQ_rd   = rd;
    ptr_din = din;
    din_lo  = din[9:0];
    do_pop  = rd && (sb.size() != 0);
    do_push = wr && (sb.size() != DEPTH);
    if (do_pop) begin
      exp_v = sb.pop_front();
      check_eq("pop_head", ptr_dout_s, exp_v);
    end
    if (do_push) sb.push_back(din_lo);
    @(posedge clk);
    @(negedge clk);
    FQ_wr = 1'b0;
    FQ_rd = 1'b0;
    check_eq("count", FQ_count, sb.size());
    check_eq("empty", ptr_fifo_empty, (sb.size() == 0) ? 1 : 0);
    if (sb.size() != 0) check_eq("head", ptr_dout_s, sb[0]);
  endtask

  // Entered on a negedge right after rstn release; counts edges until FQ_act.
  task automatic wait_init();
    int unsigned n;
    n = 0;
    while (!FQ_act && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("init_len", n, DEPTH);
    @(negedge clk);
    sb.delete();
    for (int i = 0; i < int'(DEPTH); i++) sb.push_back(i);
    check_eq("init_count", FQ_count, DEPTH);
    check_eq("init_empty", ptr_fifo_empty, 0);
    check_eq("init_head", ptr_dout_s, 0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rstn    = 1'b0;
    FQ_wr   = 1'b0;
    FQ_rd   = 1'b0;
    ptr_din = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_act", FQ_act, 0);
    check_eq("rst_empty", ptr_fifo_empty, 1);
    check_eq("rst_count", FQ_count, 0);

    // Inputs during init must be ignored.
    rstn  = 1'b1;
    FQ_wr = 1'b1;
    FQ_rd = 1'b1;
    ptr_din = 16'h03FF;
    wait_init();
    FQ_wr = 1'b0;
    FQ_rd = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0);
    check_eq("pop3_head", ptr_dout_s, 3);
    check_eq("pop3_count", FQ_count, 509);

    while (sb.size() != 0) step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    check_eq("underflow_count", FQ_count, 0);
    check_eq("underflow_empty", ptr_fifo_empty, 1);

    // Push+pop on empty is push only.
    step(1'b1, 1'b1, 16'hFC2A);
    check_eq("push_empty_head", ptr_dout_s, 10'h02A);
    check_eq("push_empty_count", FQ_count, 1);

    // Walk indices near the top, then straddle the wrap with count 5.
    for (int i = 0; i < 500; i++) step(1'b1, 1'b1, 16'($urandom));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'($urandom));
    check_eq("count5", FQ_count, 5);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 16'($urandom));
    check_eq("wrap_count", FQ_count, 5);

    while (sb.size() != DEPTH) step(1'b1, 1'b0, 16'($urandom));
    step(1'b1, 1'b0, 16'h0155);
    check_eq("overflow_count", FQ_count, DEPTH);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h0);

    // Reset in the middle of init restarts it from pointer 0.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_eq("midrst_act", FQ_act, 0);
    check_eq("midrst_count", FQ_count, 0);
    check_eq("midrst_empty", ptr_fifo_empty, 1);
    @(negedge clk);
    rstn = 1'b1;
    wait_init();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
